kmeans_centroid_update_k3_d5: RTL and testbench

//  Consumer end of the k=3, d=5 k-means assignment pipeline. Takes each (point, selected_centroid)

---
 rtl/kmeans_pkg.sv | 22 ++
 rtl/kmeans_seq_divider.sv | 49 ++++
 rtl/kmeans_centroid_update_k3_d5.sv | 168 ++++++++++++++++
 tb/tb_kmeans_centroid_update_k3_d5.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/kmeans_pkg.sv
// Shared k-means constants: cluster/dimension counts, index width, update FSM encoding.
package kmeans_pkg;
  localparam int K          = 3;
  localparam int D          = 5;
  localparam int IDX_W      = 2;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 16;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DIVIDE,
    ST_EMIT
  } upd_state_t;

  // Sum width that cannot overflow before the member counter saturates.
  function automatic int acc_width(input int data_w, input int cnt_w);
    return data_w + cnt_w;
  endfunction
endpackage

// File: rtl/kmeans_seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, MSB first, ACC_W cycles after i_start.
module kmeans_seq_divider #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [ACC_W-1:0] i_dividend,
  input  logic [CNT_W-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_last,
  output logic [ACC_W-1:0] o_quot
);
  localparam int STEP_W = $clog2(ACC_W + 1);

  logic [ACC_W-1:0]  r_quot;
  logic [CNT_W:0]    r_rem;
  logic [CNT_W-1:0]  r_div;
  logic [STEP_W-1:0] r_step;
  logic [CNT_W:0]    w_shift;
  logic              w_ge;

  // Remainder stays below the divisor, so one extra bit holds the shifted value.
  assign w_shift = {r_rem[CNT_W-1:0], r_quot[ACC_W-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_quot <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_step <= '0;
    end else if (i_start) begin
      r_quot <= i_dividend;
      r_rem  <= '0;
      r_div  <= i_divisor;
      r_step <= STEP_W'(ACC_W);
    end else if (r_step != '0) begin
      r_rem  <= w_ge ? (w_shift - {1'b0, r_div}) : w_shift;
      r_quot <= {r_quot[ACC_W-2:0], w_ge};
      r_step <= r_step - STEP_W'(1);
    end
  end

  assign o_busy = (r_step != '0);
  assign o_last = (r_step == STEP_W'(1));
  assign o_quot = r_quot;
endmodule

// File: rtl/kmeans_centroid_update_k3_d5.sv
// Accumulates per-cluster sums/counts, then on epoch_end divides and streams 3 new centroids.
// KMEANS_UPDATE_ROUNDING_EN selects round-half-up instead of floor division.
module kmeans_centroid_update_k3_d5
  import kmeans_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH = DATA_W_DEF,
  parameter int COUNT_WIDTH      = CNT_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [INPUT_DATA_WIDTH-1:0] input_data0,
  input  logic [INPUT_DATA_WIDTH-1:0] input_data1,
  input  logic [INPUT_DATA_WIDTH-1:0] input_data2,
  input  logic [INPUT_DATA_WIDTH-1:0] input_data3,
  input  logic [INPUT_DATA_WIDTH-1:0] input_data4,
  input  logic [IDX_W-1:0]            selected_centroid,
  input  logic                        epoch_end,
  output logic                        busy,
  output logic                        out_valid,
  output logic [IDX_W-1:0]            out_idx,
  output logic [INPUT_DATA_WIDTH-1:0] out_d0,
  output logic [INPUT_DATA_WIDTH-1:0] out_d1,
  output logic [INPUT_DATA_WIDTH-1:0] out_d2,
  output logic [INPUT_DATA_WIDTH-1:0] out_d3,
  output logic [INPUT_DATA_WIDTH-1:0] out_d4,
  output logic                        out_empty,
  output logic                        done,
  output logic                        drop_err,
  output logic                        sat_err
);
  localparam int ACC_W = acc_width(INPUT_DATA_WIDTH, COUNT_WIDTH);

  logic [ACC_W-1:0]            r_sum [K][D];
  logic [COUNT_WIDTH-1:0]      r_cnt [K];
  upd_state_t                  r_state, w_next;
  logic [IDX_W-1:0]            r_idx;
  logic                        r_empty, r_done, r_drop, r_sat;
  logic [INPUT_DATA_WIDTH-1:0] w_in [D];
  logic [INPUT_DATA_WIDTH-1:0] w_out_d [D];
  logic [ACC_W-1:0]            w_cur_sum [D];
  logic [ACC_W-1:0]            w_dividend [D];
  logic [ACC_W-1:0]            w_quot [D];
  logic [COUNT_WIDTH-1:0]      w_cur_cnt;
  logic                        w_cur_empty, w_div_start;
  logic [D-1:0]                w_div_busy, w_div_last;

  assign w_in[0] = input_data0;
  assign w_in[1] = input_data1;
  assign w_in[2] = input_data2;
  assign w_in[3] = input_data3;
  assign w_in[4] = input_data4;

  // Accumulation only in IDLE; the final EMIT edge wipes the epoch's statistics.
  always_ff @(posedge clk) begin
    if (!rst_n || (r_state == ST_EMIT && r_idx == LAST_IDX)) begin
      for (int k = 0; k < K; k++) begin
        r_cnt[k] <= '0;
        for (int d = 0; d < D; d++) r_sum[k][d] <= '0;
      end
    end else if (r_state == ST_IDLE && in_valid) begin
      for (int k = 0; k < K; k++) begin
        if (selected_centroid == IDX_W'(k) && r_cnt[k] != '1) begin
          r_cnt[k] <= r_cnt[k] + COUNT_WIDTH'(1);
          for (int d = 0; d < D; d++) r_sum[k][d] <= r_sum[k][d] + ACC_W'(w_in[d]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop <= 1'b0;
      r_sat  <= 1'b0;
    end else begin
      if (r_state != ST_IDLE && in_valid) r_drop <= 1'b1;
      if (r_state == ST_IDLE && in_valid) begin
        for (int k = 0; k < K; k++)
          if (selected_centroid == IDX_W'(k) && r_cnt[k] == '1) r_sat <= 1'b1;
      end
    end
  end

  always_comb begin
    w_cur_cnt = '0;
    for (int d = 0; d < D; d++) w_cur_sum[d] = '0;
    for (int k = 0; k < K; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_cur_cnt = r_cnt[k];
        for (int d = 0; d < D; d++) w_cur_sum[d] = r_sum[k][d];
      end
    end
  end

  assign w_cur_empty = (w_cur_cnt == '0);
  assign w_div_start = (r_state == ST_LOAD) && !w_cur_empty;

  always_comb begin
    for (int d = 0; d < D; d++) begin
`ifdef KMEANS_UPDATE_ROUNDING_EN
      w_dividend[d] = w_cur_sum[d] + ACC_W'(w_cur_cnt >> 1);
`else
      w_dividend[d] = w_cur_sum[d];
`endif
    end
  end

  for (genvar g = 0; g < D; g++) begin : g_div
    kmeans_seq_divider #(.ACC_W(ACC_W), .CNT_W(COUNT_WIDTH)) u_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_start    (w_div_start),
      .i_dividend (w_dividend[g]),
      .i_divisor  (w_cur_cnt),
      .o_busy     (w_div_busy[g]),
      .o_last     (w_div_last[g]),
      .o_quot     (w_quot[g])
    );
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (epoch_end) w_next = ST_LOAD;
      ST_LOAD:   w_next = w_cur_empty ? ST_EMIT : ST_DIVIDE;
      ST_DIVIDE: if (w_div_last == '1) w_next = ST_EMIT;
      ST_EMIT:   w_next = (r_idx == LAST_IDX) ? ST_IDLE : ST_LOAD;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_empty <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == ST_EMIT) && (r_idx == LAST_IDX);
      if (r_state == ST_IDLE && epoch_end) r_idx <= '0;
      else if (r_state == ST_EMIT && r_idx != LAST_IDX) r_idx <= r_idx + IDX_W'(1);
      if (r_state == ST_LOAD) r_empty <= w_cur_empty;
    end
  end

  // Quotient can only exceed the coordinate range if sums were corrupted; clamp anyway.
  always_comb begin
    for (int d = 0; d < D; d++) begin
      w_out_d[d] = '0;
      if (out_valid && !r_empty)
        w_out_d[d] = (|w_quot[d][ACC_W-1:INPUT_DATA_WIDTH]) ? '1 : w_quot[d][INPUT_DATA_WIDTH-1:0];
    end
  end

  assign busy      = (r_state != ST_IDLE) || (|w_div_busy);
  assign out_valid = (r_state == ST_EMIT);
  assign out_idx   = out_valid ? r_idx : '0;
  assign out_empty = out_valid && r_empty;
  assign out_d0    = w_out_d[0];
  assign out_d1    = w_out_d[1];
  assign out_d2    = w_out_d[2];
  assign out_d3    = w_out_d[3];
  assign out_d4    = w_out_d[4];
  assign done      = r_done;
  assign drop_err  = r_drop;
  assign sat_err   = r_sat;
endmodule

// File: tb/tb_kmeans_centroid_update_k3_d5.sv
// Directed bench for the centroid update block; expected results hand-computed per scenario.
module tb_kmeans_centroid_update_k3_d5;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, epoch_end;
  logic [15:0] in_d0, in_d1, in_d2, in_d3, in_d4;
  logic [1:0]  sel;
  logic        busy, out_valid, out_empty, done, drop_err, sat_err;
  logic [1:0]  out_idx;
  logic [15:0] out_d0, out_d1, out_d2, out_d3, out_d4;

  int          n_pass = 0;
  int          n_total = 0;
  int          n_out;
  int          done_at;
  int          stray;
  logic [15:0] res_d [3][5];
  logic        res_empty [3];
  logic [1:0]  res_idx [3];
  logic [15:0] k1_d0_exp;

  kmeans_centroid_update_k3_d5 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .input_data0(in_d0), .input_data1(in_d1), .input_data2(in_d2),
    .input_data3(in_d3), .input_data4(in_d4),
    .selected_centroid(sel), .epoch_end(epoch_end),
    .busy(busy), .out_valid(out_valid), .out_idx(out_idx),
    .out_d0(out_d0), .out_d1(out_d1), .out_d2(out_d2), .out_d3(out_d3), .out_d4(out_d4),
    .out_empty(out_empty), .done(done), .drop_err(drop_err), .sat_err(sat_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic set_pt(input logic [1:0] s, input logic [15:0] a, b, c, d, e);
    sel = s; in_d0 = a; in_d1 = b; in_d2 = c; in_d3 = d; in_d4 = e;
  endtask

  task automatic send_pt(input logic [1:0] s, input logic [15:0] a, b, c, d, e);
    set_pt(s, a, b, c, d, e);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Raises epoch_end (optionally with a coincident point) and records every emitted centroid.
  task automatic run_epoch(input bit with_pt, input logic [1:0] ps, input logic [15:0] pv,
                           input bit inject_drop);
    n_out = 0;
    done_at = 0;
    epoch_end = 1'b1;
    if (with_pt) begin
      set_pt(ps, pv, pv, pv, pv, pv);
      in_valid = 1'b1;
    end
    tick();
    epoch_end = 1'b0;
    in_valid = 1'b0;
    check("busy_after_epoch_end", busy, 1);
    for (int c = 1; c <= 300 && done_at == 0; c++) begin
      if (inject_drop && c == 10) begin
        set_pt(2'd0, 16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd1000);
        in_valid = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      if (out_valid) begin
        if (n_out < 3) begin
          res_idx[n_out]   = out_idx;
          res_empty[n_out] = out_empty;
          res_d[n_out][0] = out_d0; res_d[n_out][1] = out_d1; res_d[n_out][2] = out_d2;
          res_d[n_out][3] = out_d3; res_d[n_out][4] = out_d4;
        end
        n_out++;
      end
      if (done) done_at = c;
    end
    check("done_seen", (done_at != 0), 1);
    check("out_valid_count", n_out, 3);
    check("busy_after_done", busy, 0);
    for (int i = 0; i < 3 && i < n_out; i++) check("out_idx_order", res_idx[i], i);
  endtask

  task automatic check_centroid(input int k, input logic [15:0] a, b, c, d, e, input logic emp);
    if (k >= n_out) begin
      check("centroid_missing", n_out, k + 1);
    end else begin
      check($sformatf("k%0d_empty", k), res_empty[k], emp);
      check($sformatf("k%0d_d0", k), res_d[k][0], a);
      check($sformatf("k%0d_d1", k), res_d[k][1], b);
      check($sformatf("k%0d_d2", k), res_d[k][2], c);
      check($sformatf("k%0d_d3", k), res_d[k][3], d);
      check($sformatf("k%0d_d4", k), res_d[k][4], e);
    end
  endtask

  initial begin
`ifdef KMEANS_UPDATE_ROUNDING_EN
    k1_d0_exp = 16'd2;
`else
    k1_d0_exp = 16'd1;
`endif
    rst_n = 1'b0; in_valid = 1'b0; epoch_end = 1'b0;
    set_pt(2'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    tick(); tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_d0", out_d0, 0);
    check("rst_out_empty", out_empty, 0);
    check("rst_done", done, 0);
    check("rst_drop_err", drop_err, 0);
    check("rst_sat_err", sat_err, 0);

    // Epoch with no points: three empty results, 2 cycles each
    run_epoch(1'b0, 2'd0, 16'd0, 1'b0);
    check("empty_epoch_done_cycle", done_at, 6);
    for (int k = 0; k < 3; k++) check_centroid(k, 0, 0, 0, 0, 0, 1'b1);

    // Mixed points, an invalid-index point, and a dropped point while busy
    send_pt(2'd0, 16'd10, 16'd20, 16'd30, 16'd40, 16'd50);
    send_pt(2'd3, 16'd999, 16'd999, 16'd999, 16'd999, 16'd999);
    send_pt(2'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0);
    send_pt(2'd0, 16'd20, 16'd40, 16'd60, 16'd80, 16'd100);
    send_pt(2'd2, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7);
    send_pt(2'd1, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0);
    check("drop_err_before_busy", drop_err, 0);
    run_epoch(1'b0, 2'd0, 16'd0, 1'b1);
    check("full_epoch_done_cycle", done_at, 102);
    check_centroid(0, 15, 30, 45, 60, 75, 1'b0);
    check_centroid(1, k1_d0_exp, 0, 0, 0, 0, 1'b0);
    check_centroid(2, 7, 7, 7, 7, 7, 1'b0);
    check("drop_err_set", drop_err, 1);

    // Point coincident with epoch_end is included; sums were cleared by previous epoch
    send_pt(2'd0, 16'd8, 16'd8, 16'd8, 16'd8, 16'd8);
    send_pt(2'd2, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9);
    run_epoch(1'b1, 2'd1, 16'd5, 1'b0);
    check("coincident_done_cycle", done_at, 102);
    check_centroid(0, 8, 8, 8, 8, 8, 1'b0);
    check_centroid(1, 5, 5, 5, 5, 5, 1'b0);
    check_centroid(2, 9, 9, 9, 9, 9, 1'b0);
    check("drop_err_sticky", drop_err, 1);
    check("sat_err_clear", sat_err, 0);

    // Reset in the middle of DIVIDE aborts the epoch
    send_pt(2'd0, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100);
    epoch_end = 1'b1;
    tick();
    epoch_end = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    check("mid_divide_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_d0", out_d0, 0);
    check("abort_done", done, 0);
    check("abort_drop_err", drop_err, 0);
    stray = 0;
    for (int c = 0; c < 120; c++) begin
      tick();
      if (out_valid || done) stray++;
    end
    check("abort_no_stray_outputs", stray, 0);

    send_pt(2'd0, 16'd4, 16'd4, 16'd4, 16'd4, 16'd4);
    run_epoch(1'b0, 2'd0, 16'd0, 1'b0);
    check("post_reset_done_cycle", done_at, 38);
    check_centroid(0, 4, 4, 4, 4, 4, 1'b0);
    check_centroid(1, 0, 0, 0, 0, 0, 1'b1);
    check_centroid(2, 0, 0, 0, 0, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
